frame_check_receive_fifo: RTL and testbench

//  Downstream consumer of the synchronized/debounced serial shift register. Counts debounced serial-clock

---
 rtl/frame_check_receive_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_frame_check_receive_fifo.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_check_receive_fifo.sv
// rtl/frame_check_receive_fifo.sv - serial frame capture, init/parity check and receive FIFO
// Define FRAME_CHECK_ERR_COUNT_EN to add saturating error counters and clear_counts.
module frame_check_receive_fifo #(
   parameter int         FRAME_BITS     = 11,
   parameter int         FIFO_DEPTH     = 4,
   parameter logic [1:0] INIT_PATTERN   = 2'b10,
   parameter bit         PARITY_ODD     = 1'b0,
   parameter int         SETTLE_CYCLES  = 2,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic       control_clock,
   input  logic       reset_n,
   input  logic       synced_clock,
   input  logic [7:0] parallel_data_buffer,
   input  logic [1:0] comm_init_bits,
   input  logic       parity_check_bit,
   output logic       confirm_send_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       fifo_full,
   output logic       frame_error,
   output logic       parity_error,
   output logic       overflow
`ifdef FRAME_CHECK_ERR_COUNT_EN
   ,
   input  logic       clear_counts,
   output logic [7:0] frame_err_count,
   output logic [7:0] parity_err_count,
   output logic [7:0] overflow_count
`endif
);

   localparam int BCW = $clog2(FRAME_BITS + 1);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;

   localparam logic [BCW-1:0] LP_LAST_BIT    = BCW'(FRAME_BITS - 1);
   localparam logic [BCW-1:0] LP_BIT_ONE     = BCW'(1);
   localparam logic [TW-1:0]  LP_TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]  LP_TO_ONE      = TW'(1);
   localparam logic [3:0]     LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0]  LP_DEPTH       = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]  LP_CNT_ONE     = CW'(1);
   localparam logic [PW-1:0]  LP_PTR_ONE     = PW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECEIVE,
      S_SETTLE,
      S_CHECK
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_prev;
   logic           w_rise;
   logic [BCW-1:0] r_bit_cnt;
   logic [TW-1:0]  r_timer;
   logic [3:0]     r_settle_cnt;
   logic [7:0]     r_cap_data;
   logic [1:0]     r_cap_init;
   logic           r_cap_par;
   logic           w_init_ok;
   logic           w_par_ok;
   logic           w_push_req;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic [7:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   assign w_rise    = synced_clock & ~r_prev;
   assign w_init_ok = (r_cap_init == INIT_PATTERN);
   assign w_par_ok  = ((^{r_cap_data, r_cap_par}) == PARITY_ODD);

   always_ff @(posedge control_clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next            = r_state;
      confirm_send_data = 1'b0;
      frame_error       = 1'b0;
      parity_error      = 1'b0;
      w_push_req        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise)
               w_next = S_RECEIVE;
         end
         S_RECEIVE: begin
            if (w_rise) begin
               if (r_bit_cnt == LP_LAST_BIT)
                  w_next = S_SETTLE;
            end else if (r_timer == LP_TO_LAST) begin
               w_next      = S_IDLE;
               frame_error = 1'b1;
            end
         end
         S_SETTLE: begin
            if (r_settle_cnt == LP_SETTLE_LAST)
               w_next = S_CHECK;
         end
         S_CHECK: begin
            // Init mismatch masks any parity result for the same frame.
            confirm_send_data = 1'b1;
            w_next            = S_IDLE;
            if (!w_init_ok)
               frame_error = 1'b1;
            else if (!w_par_ok)
               parity_error = 1'b1;
            else
               w_push_req = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge control_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prev       <= 1'b0;
         r_bit_cnt    <= '0;
         r_timer      <= '0;
         r_settle_cnt <= '0;
         r_cap_data   <= '0;
         r_cap_init   <= '0;
         r_cap_par    <= 1'b0;
      end else begin
         r_prev <= synced_clock;
         case (r_state)
            S_IDLE: begin
               r_timer      <= '0;
               r_settle_cnt <= '0;
               r_bit_cnt    <= w_rise ? LP_BIT_ONE : '0;
            end
            S_RECEIVE: begin
               if (w_rise) begin
                  r_bit_cnt <= r_bit_cnt + LP_BIT_ONE;
                  r_timer   <= '0;
               end else begin
                  r_timer <= r_timer + LP_TO_ONE;
               end
            end
            S_SETTLE: begin
               // Inputs are given SETTLE_CYCLES to stabilise after the final edge.
               if (r_settle_cnt == LP_SETTLE_LAST) begin
                  r_settle_cnt <= '0;
                  r_cap_data   <= parallel_data_buffer;
                  r_cap_init   <= comm_init_bits;
                  r_cap_par    <= parity_check_bit;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 4'd1;
               end
            end
            S_CHECK: begin
               r_bit_cnt <= '0;
            end
            default: begin
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

   assign w_full    = (r_count == LP_DEPTH);
   assign rx_valid  = (r_count != '0);
   assign fifo_full = w_full;
   assign w_pop     = rx_valid & rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push    = w_push_req & (~w_full | w_pop);
   assign overflow  = w_push_req & w_full & ~w_pop;
   assign rx_data   = r_mem[r_rd_ptr];

   always_ff @(posedge control_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= r_cap_data;
            r_wr_ptr        <= r_wr_ptr + LP_PTR_ONE;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FRAME_CHECK_ERR_COUNT_EN
   logic [7:0] r_frame_err_count;
   logic [7:0] r_parity_err_count;
   logic [7:0] r_overflow_count;

   always_ff @(posedge control_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_err_count  <= '0;
         r_parity_err_count <= '0;
         r_overflow_count   <= '0;
      end else if (clear_counts) begin
         r_frame_err_count  <= '0;
         r_parity_err_count <= '0;
         r_overflow_count   <= '0;
      end else begin
         if (frame_error && (r_frame_err_count != 8'hFF))
            r_frame_err_count <= r_frame_err_count + 8'd1;
         if (parity_error && (r_parity_err_count != 8'hFF))
            r_parity_err_count <= r_parity_err_count + 8'd1;
         if (overflow && (r_overflow_count != 8'hFF))
            r_overflow_count <= r_overflow_count + 8'd1;
      end
   end

   assign frame_err_count  = r_frame_err_count;
   assign parity_err_count = r_parity_err_count;
   assign overflow_count   = r_overflow_count;
`endif

endmodule

// File: tb/tb_frame_check_receive_fifo.sv
// tb/tb_frame_check_receive_fifo.sv - randomized self-checking bench for frame_check_receive_fifo
module tb_frame_check_receive_fifo;

   localparam int         SETTLE  = 2;
   localparam int         DEPTH   = 4;
   localparam int         NBITS   = 11;
   localparam logic [1:0] INIT_OK = 2'b10;
   localparam bit         PODD    = 1'b0;

   logic       control_clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       synced_clock = 1'b0;
   logic [7:0] parallel_data_buffer = 8'h00;
   logic [1:0] comm_init_bits = 2'b00;
   logic       parity_check_bit = 1'b0;
   logic       rx_ready = 1'b0;
   logic       confirm_send_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       fifo_full;
   logic       frame_error;
   logic       parity_error;
   logic       overflow;

   int n_pass  = 0;
   int n_total = 0;

   int cnt_conf = 0;
   int cnt_ferr = 0;
   int cnt_perr = 0;
   int cnt_ovf  = 0;
   logic [7:0] popped[$];

   always #5 control_clock = ~control_clock;

   frame_check_receive_fifo dut (
      .control_clock        (control_clock),
      .reset_n              (reset_n),
      .synced_clock         (synced_clock),
      .parallel_data_buffer (parallel_data_buffer),
      .comm_init_bits       (comm_init_bits),
      .parity_check_bit     (parity_check_bit),
      .confirm_send_data    (confirm_send_data),
      .rx_data              (rx_data),
      .rx_valid             (rx_valid),
      .rx_ready             (rx_ready),
      .fifo_full            (fifo_full),
      .frame_error          (frame_error),
      .parity_error         (parity_error),
      .overflow             (overflow)
   );

   always @(negedge control_clock) begin
      if (confirm_send_data) cnt_conf++;
      if (frame_error)       cnt_ferr++;
      if (parity_error)      cnt_perr++;
      if (overflow)          cnt_ovf++;
      if (rx_valid && rx_ready) popped.push_back(rx_data);
   end

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ PODD;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge control_clock);
      #1;
   endtask

   task automatic pulse_bit();
      synced_clock = 1'b1;
      cyc($urandom_range(1, 3));
      synced_clock = 1'b0;
      cyc($urandom_range(1, 3));
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] ini, input logic p);
      parallel_data_buffer = d;
      comm_init_bits       = ini;
      parity_check_bit     = p;
      for (int i = 0; i < NBITS; i++) pulse_bit();
      cyc(SETTLE + 4);
   endtask

   task automatic flush();
      rx_ready = 1'b1;
      cyc(DEPTH + 2);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      cyc(3);
      n_total++;
      if ({rx_valid, fifo_full, confirm_send_data, frame_error, parity_error, overflow} !== 6'b0)
         $display("FAIL reset_flags: got %b expected 000000",
                  {rx_valid, fifo_full, confirm_send_data, frame_error, parity_error, overflow});
      else n_pass++;
      n_total++;
      if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data);
      else n_pass++;
      reset_n = 1'b1;
      cyc(2);
      n_total++;
      if ({rx_valid, fifo_full, confirm_send_data, frame_error, parity_error, overflow} !== 6'b0)
         $display("FAIL post_reset_flags: got %b expected 000000",
                  {rx_valid, fifo_full, confirm_send_data, frame_error, parity_error, overflow});
      else n_pass++;
   endtask

   task automatic test_first_frame();
      int b_conf;
      b_conf = cnt_conf;
      rx_ready             = 1'b0;
      parallel_data_buffer = 8'hA5;
      comm_init_bits       = INIT_OK;
      parity_check_bit     = 1'b0;
      for (int i = 0; i < NBITS - 1; i++) pulse_bit();
      synced_clock = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge control_clock);
         @(negedge control_clock);
         if (k == 1) synced_clock = 1'b0;
         n_total++;
         if (rx_valid !== (k >= SETTLE + 2))
            $display("FAIL latency_valid_k%0d: got %b expected %b", k, rx_valid, (k >= SETTLE + 2));
         else n_pass++;
         if (k == SETTLE + 2) begin
            n_total++;
            if (rx_data !== 8'hA5) $display("FAIL first_data: got %h expected a5", rx_data);
            else n_pass++;
         end
      end
      cyc(2);
      n_total++;
      if (cnt_conf - b_conf !== 1) $display("FAIL first_confirm: got %0d pulses expected 1", cnt_conf - b_conf);
      else n_pass++;
      flush();
   endtask

   task automatic test_parity_error();
      int b_perr, b_ferr, b_conf;
      b_perr = cnt_perr; b_ferr = cnt_ferr; b_conf = cnt_conf;
      send_frame(8'h01, INIT_OK, 1'b0);
      n_total++;
      if (cnt_perr - b_perr !== 1) $display("FAIL parity_pulse: got %0d expected 1", cnt_perr - b_perr);
      else n_pass++;
      n_total++;
      if (cnt_ferr - b_ferr !== 0) $display("FAIL parity_no_ferr: got %0d expected 0", cnt_ferr - b_ferr);
      else n_pass++;
      n_total++;
      if (rx_valid !== 1'b0) $display("FAIL parity_no_push: got %b expected 0", rx_valid);
      else n_pass++;
      n_total++;
      if (cnt_conf - b_conf !== 1) $display("FAIL parity_confirm: got %0d expected 1", cnt_conf - b_conf);
      else n_pass++;
   endtask

   task automatic test_init_error();
      int b_perr, b_ferr;
      b_perr = cnt_perr; b_ferr = cnt_ferr;
      send_frame(8'h3B, 2'b01, ~good_par(8'h3B));
      n_total++;
      if (cnt_ferr - b_ferr !== 1) $display("FAIL init_ferr: got %0d expected 1", cnt_ferr - b_ferr);
      else n_pass++;
      n_total++;
      if (cnt_perr - b_perr !== 0) $display("FAIL init_no_perr: got %0d expected 0", cnt_perr - b_perr);
      else n_pass++;
      n_total++;
      if (rx_valid !== 1'b0) $display("FAIL init_no_push: got %b expected 0", rx_valid);
      else n_pass++;
   endtask

   task automatic test_fifo_full();
      int b_ovf, base;
      logic [7:0] d, got;
      b_ovf = cnt_ovf;
      base  = popped.size();
      rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = 8'(8'h10 + i);
         send_frame(d, INIT_OK, good_par(d));
         if (i == 2) begin
            n_total++;
            if (fifo_full !== 1'b0) $display("FAIL fifo_not_full_3: got %b expected 0", fifo_full);
            else n_pass++;
         end
         if (i == 3) begin
            n_total++;
            if (fifo_full !== 1'b1) $display("FAIL fifo_full_4: got %b expected 1", fifo_full);
            else n_pass++;
            n_total++;
            if (cnt_ovf - b_ovf !== 0) $display("FAIL no_ovf_4: got %0d expected 0", cnt_ovf - b_ovf);
            else n_pass++;
         end
      end
      n_total++;
      if (cnt_ovf - b_ovf !== 1) $display("FAIL ovf_5: got %0d expected 1", cnt_ovf - b_ovf);
      else n_pass++;
      flush();
      n_total++;
      if (popped.size() - base !== DEPTH) $display("FAIL drain_count: got %0d expected %0d", popped.size() - base, DEPTH);
      else n_pass++;
      for (int j = 0; j < DEPTH; j++) begin
         got = (base + j < popped.size()) ? popped[base + j] : 8'hxx;
         n_total++;
         if (got !== 8'(8'h10 + j)) $display("FAIL drain_order_%0d: got %h expected %h", j, got, 8'(8'h10 + j));
         else n_pass++;
      end
      n_total++;
      if (rx_valid !== 1'b0) $display("FAIL drain_empty: got %b expected 0", rx_valid);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int b_ferr, b_conf, base;
      logic [7:0] got;
      b_ferr = cnt_ferr; b_conf = cnt_conf;
      parallel_data_buffer = 8'h77;
      for (int i = 0; i < 6; i++) pulse_bit();
      cyc(1000);
      n_total++;
      if (cnt_ferr - b_ferr !== 0) $display("FAIL timeout_early: got %0d expected 0", cnt_ferr - b_ferr);
      else n_pass++;
      cyc(100);
      n_total++;
      if (cnt_ferr - b_ferr !== 1) $display("FAIL timeout_pulse: got %0d expected 1", cnt_ferr - b_ferr);
      else n_pass++;
      n_total++;
      if (cnt_conf - b_conf !== 0) $display("FAIL timeout_no_capture: got %0d expected 0", cnt_conf - b_conf);
      else n_pass++;
      base = popped.size();
      send_frame(8'h3C, INIT_OK, good_par(8'h3C));
      flush();
      got = (popped.size() > base) ? popped[base] : 8'hxx;
      n_total++;
      if (popped.size() - base !== 1 || got !== 8'h3C)
         $display("FAIL after_timeout_frame: got %0d bytes head %h expected 1 byte 3c", popped.size() - base, got);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int base;
      logic [7:0] got;
      rx_ready = 1'b0;
      send_frame(8'h55, INIT_OK, good_par(8'h55));
      parallel_data_buffer = 8'h99;
      for (int i = 0; i < 5; i++) pulse_bit();
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge control_clock);
         n_total++;
         if ({rx_valid, fifo_full, confirm_send_data, frame_error, parity_error, overflow} !== 6'b0)
            $display("FAIL midreset_flags_%0d: got %b expected 000000", k,
                     {rx_valid, fifo_full, confirm_send_data, frame_error, parity_error, overflow});
         else n_pass++;
         n_total++;
         if (rx_data !== 8'h00) $display("FAIL midreset_data_%0d: got %h expected 00", k, rx_data);
         else n_pass++;
      end
      @(posedge control_clock);
      #1;
      reset_n = 1'b1;
      cyc(2);
      base = popped.size();
      send_frame(8'hC3, INIT_OK, good_par(8'hC3));
      flush();
      got = (popped.size() > base) ? popped[base] : 8'hxx;
      n_total++;
      if (popped.size() - base !== 1 || got !== 8'hC3)
         $display("FAIL midreset_only_c3: got %0d bytes head %h expected 1 byte c3", popped.size() - base, got);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] d, got;
      logic [1:0] ini;
      logic       bad_p, rdy;
      int occ, e_ferr, e_perr, e_ovf;
      int b_ferr, b_perr, b_ovf, b_conf, base;
      occ = 0; e_ferr = 0; e_perr = 0; e_ovf = 0;
      b_ferr = cnt_ferr; b_perr = cnt_perr; b_ovf = cnt_ovf; b_conf = cnt_conf;
      base = popped.size();
      for (int f = 0; f < 40; f++) begin
         d     = 8'($urandom);
         ini   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : INIT_OK;
         bad_p = ($urandom_range(0, 3) == 0);
         rdy   = 1'($urandom_range(0, 1));
         rx_ready = rdy;
         if (rdy) occ = 0;
         if (ini != INIT_OK) e_ferr++;
         else if (bad_p) e_perr++;
         else if (occ == DEPTH && !rdy) e_ovf++;
         else begin
            exp_q.push_back(d);
            if (!rdy) occ++;
         end
         send_frame(d, ini, good_par(d) ^ bad_p);
      end
      flush();
      n_total++;
      if (cnt_ferr - b_ferr !== e_ferr) $display("FAIL rand_ferr: got %0d expected %0d", cnt_ferr - b_ferr, e_ferr);
      else n_pass++;
      n_total++;
      if (cnt_perr - b_perr !== e_perr) $display("FAIL rand_perr: got %0d expected %0d", cnt_perr - b_perr, e_perr);
      else n_pass++;
      n_total++;
      if (cnt_ovf - b_ovf !== e_ovf) $display("FAIL rand_ovf: got %0d expected %0d", cnt_ovf - b_ovf, e_ovf);
      else n_pass++;
      n_total++;
      if (cnt_conf - b_conf !== 40) $display("FAIL rand_confirm: got %0d expected 40", cnt_conf - b_conf);
      else n_pass++;
      n_total++;
      if (popped.size() - base !== exp_q.size())
         $display("FAIL rand_count: got %0d expected %0d", popped.size() - base, exp_q.size());
      else n_pass++;
      for (int j = 0; j < exp_q.size(); j++) begin
         got = (base + j < popped.size()) ? popped[base + j] : 8'hxx;
         n_total++;
         if (got !== exp_q[j]) $display("FAIL rand_byte_%0d: got %h expected %h", j, got, exp_q[j]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_parity_error();
      test_init_error();
      test_fifo_full();
      test_timeout();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
